if_prefetch_unit: RTL
=====================

IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch word address.
REQ-003 The block SHALL have clk1  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have rst_n  input  1  meaning the reset, asynchronous and active-low.
REQ-005 The block SHALL have imem_req_valid  output  1  meaning an instruction-memory read request is presented.
REQ-006 The block SHALL have imem_req_addr  output  10  meaning the word address of the request, equal to pc[9:0].
REQ-007 The block SHALL have imem_req_ready  input  1  meaning memory accepts the request this cycle.
REQ-008 The block SHALL have imem_rsp_valid  input  1  meaning read data is returned, in request order, at least 1 cycle after acceptance.
REQ-009 The block SHALL have imem_rsp_data  input  32  meaning the returned instruction word.
REQ-010 The block SHALL have redirect_valid  input  1  meaning a taken branch from the execute stage.
REQ-011 The block SHALL have redirect_pc  input  32  meaning the branch target word address.
REQ-012 The block SHALL have halt  input  1  meaning stop issuing new fetches.
REQ-013 The block SHALL have id_valid  output  1  meaning id_ir and id_npc hold a valid instruction for decode.
REQ-014 The block SHALL have id_ir  output  32  meaning the fetched instruction (FIFO head).
REQ-015 The block SHALL have id_npc  output  32  meaning the fetch address of id_ir plus 1.
REQ-016 The block SHALL have id_ready  input  1  meaning decode accepts the head this cycle.

Function
REQ-017 The block SHALL hold a 32-bit pc; an accepted request (imem_req_valid && imem_req_ready) SHALL increment pc by 1, wrapping 32'hFFFFFFFF to 0.
REQ-018 The block SHALL record, per outstanding request, its fetch address plus 1 in an in-order tag queue, so id_npc always pairs with its instruction.
REQ-019 The block SHALL drive imem_req_valid = !halt && (fifo_count + outstanding) < DEPTH; a response SHALL therefore never find the FIFO full.
REQ-020 The block SHALL push every non-discarded response into the FIFO in the cycle it arrives; responses SHALL NOT be dropped or reordered.
REQ-021 The block SHALL pop the head when id_valid && id_ready; id_valid SHALL equal (fifo_count != 0).
REQ-022 Simultaneous push and pop SHALL keep fifo_count unchanged, including when fifo_count is 0 (response is registered first; no bypass) or DEPTH.
REQ-023 On redirect_valid at a clock edge, the block SHALL: clear the FIFO, set pc to redirect_pc, discard all requests outstanding after that edge, and suppress any request presented in that cycle from advancing pc past redirect_pc.
REQ-024 A decode handshake in the redirect cycle SHALL complete normally; the FIFO SHALL be empty on the next cycle.
REQ-025 The block SHALL track discards with a drop counter loaded with the post-edge outstanding count; each response arriving while the counter is nonzero SHALL be consumed and decrement it without pushing.
REQ-026 A redirect arriving while the drop counter is nonzero SHALL add the newly outstanding requests to it; no stale word SHALL ever reach id_ir.
REQ-027 A request accepted in the redirect cycle SHALL count as outstanding and be discarded.
REQ-028 While halt=1, no new requests SHALL issue; outstanding responses SHALL still be pushed and the FIFO SHALL still drain; deasserting halt SHALL resume at the current pc.
REQ-029 redirect_valid SHALL take priority over halt for pc update.

Reset
REQ-030 While rst_n=0: pc=RESET_PC, FIFO empty, outstanding=0, drop counter=0, imem_req_valid=0, id_valid=0, id_ir=0, id_npc=0.
REQ-031 Responses arriving in the first cycle after rst_n rises SHALL be ignored only if outstanding=0 (i.e. the block SHALL NOT push unsolicited data).
REQ-032 Reset asserted mid-operation SHALL abandon all in-flight requests without waiting for responses.

Verification
REQ-033 Reset, imem_req_ready=1, 1-cycle memory returning Mem[a]=a+100, id_ready=1 -> id_ir sequence 100,101,102..., id_npc 1,2,3...
REQ-034 id_ready=0 for 10 cycles -> exactly 4 requests issued, fifo full, imem_req_valid=0; release -> 4 words drained in order, no loss.
REQ-035 3-cycle memory latency, 2 outstanding, redirect_pc=40 -> both stale responses dropped; next id_ir=140, id_npc=41.
REQ-036 halt=1 with 2 outstanding -> no new requests, both words delivered; halt=0 -> fetch resumes at next sequential pc.
REQ-037 redirect_pc=32'hFFFFFFFF -> id_npc=0 next, then request address 0 (pc wrap).
REQ-038 rst_n dropped with FIFO full and 2 outstanding -> all outputs at reset values immediately; after release first request address equals RESET_PC.

Source files
------------

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetch unit.
// Issues sequential word fetches to instruction memory, keeps an in-order tag
// queue of (fetch address + 1) for every request in flight, and buffers the
// returned words in a small FIFO feeding decode. A redirect flushes the FIFO,
// reloads pc, and arms a down-counter that swallows the stale responses still
// on their way back from memory.
module if_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk1,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [9:0]  imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  output logic [31:0] id_ir,
  output logic [31:0] id_npc,
  input  logic        id_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   pc_q;
  logic          run_q;

  logic [31:0]   tag_mem [DEPTH];
  logic [AW-1:0] tag_rd;
  logic [AW-1:0] tag_wr;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] drop_cnt;

  logic [31:0]   fifo_ir  [DEPTH];
  logic [31:0]   fifo_npc [DEPTH];
  logic [AW-1:0] fifo_rd;
  logic [AW-1:0] fifo_wr;
  logic [CW-1:0] fifo_cnt;

  logic [CW:0]   in_flight;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_drop;
  logic          push;
  logic          pop;

  // Everything fetched but not yet handed to decode must fit in the FIFO, so a
  // response can always be written in the cycle it arrives. Dropped requests
  // still count until their response comes back, which keeps the tag queue
  // from overflowing as well.
  assign in_flight      = {1'b0, fifo_cnt} + {1'b0, out_cnt};
  assign imem_req_valid = run_q && !halt && (in_flight < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q[9:0];
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is unsolicited and is ignored.
  assign rsp_take = imem_rsp_valid && (out_cnt != '0);
  assign rsp_drop = rsp_take && (drop_cnt != '0);
  // A response landing in a redirect cycle belongs to the old stream.
  assign push     = rsp_take && !rsp_drop && !redirect_valid;

  assign id_valid = (fifo_cnt != '0);
  assign pop      = id_valid && id_ready;
  assign id_ir    = id_valid ? fifo_ir[fifo_rd]  : '0;
  assign id_npc   = id_valid ? fifo_npc[fifo_rd] : '0;

  assign out_nxt  = out_cnt + CW'(req_fire) - CW'(rsp_take);

  // pc update; run_q holds off requests while reset is asserted and for the
  // first cycle after release so no request is ever presented under reset.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (req_fire) begin
        pc_q <= pc_q + 32'd1;
      end
    end
  end

  // Tag queue pointers and outstanding count, one entry per request in flight.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      tag_rd  <= '0;
      tag_wr  <= '0;
      out_cnt <= '0;
    end else begin
      if (req_fire) begin
        tag_wr <= tag_wr + AW'(1);
      end
      if (rsp_take) begin
        tag_rd <= tag_rd + AW'(1);
      end
      out_cnt <= out_nxt;
    end
  end

  // Tag storage: the npc that will accompany each returning word.
  always_ff @(posedge clk1) begin
    if (req_fire) begin
      tag_mem[tag_wr] <= pc_q + 32'd1;
    end
  end

  // Drop down-counter: on redirect every request still outstanding after the
  // edge (including one accepted in the redirect cycle) becomes stale.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= out_nxt;
    end else if (rsp_drop) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // FIFO pointers and occupancy; a redirect empties it regardless of pop.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      fifo_cnt <= '0;
    end else if (redirect_valid) begin
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_wr <= fifo_wr + AW'(1);
      end
      if (pop) begin
        fifo_rd <= fifo_rd + AW'(1);
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; the word and its tag are written together.
  always_ff @(posedge clk1) begin
    if (push) begin
      fifo_ir[fifo_wr]  <= imem_rsp_data;
      fifo_npc[fifo_wr] <= tag_mem[tag_rd];
    end
  end

endmodule
